// File: rtl/aes_key_schedule_multi.sv
// aes_key_schedule_multi: iterative AES-128/192/256 key expansion, one schedule word per cycle
module aes_key_schedule_multi #(
    parameter int DATA_W      = 128,
    parameter int MAX_KEY_LEN = 256,
    parameter int MAX_ROUNDS  = 14
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               valid_in,
    output logic                               ready,
    input  logic [1:0]                         key_size,
    input  logic [MAX_KEY_LEN-1:0]             cipher_key,
    input  logic [3:0]                         rk_addr,
    output logic [DATA_W-1:0]                  rk_data,
    output logic [(MAX_ROUNDS+1)*DATA_W-1:0]   super_key,
    output logic [MAX_ROUNDS:0]                valid_out,
    output logic                               busy,
    output logic                               done,
    output logic [3:0]                         num_rounds
);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {S_IDLE, S_GEN, S_DONE} state_t;

    state_t                  state, next_state;
    logic [DATA_W-1:0]       rk [0:MAX_ROUNDS];
    logic [31:0]             win [0:7];
    logic [5:0]              idx, last;
    logic [2:0]              cnt, cnt_max, off, in_off;
    logic [1:0]              ks;
    logic [7:0]              rcon;
    logic                    accept;
    logic [31:0]             prev, sub_in, sub, temp, word;
    logic [MAX_KEY_LEN-1:0]  key_shift;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[8*(255-int'(x)) +: 8];
    endfunction

    // Window holds the last 8 words with the newest in win[7]; w[i-Nk] sits at win[8-Nk]
    always_comb begin
        accept    = state == S_IDLE && valid_in && key_size != 2'd3;
        off       = ks == 2'd2 ? 3'd0 : ks == 2'd1 ? 3'd2 : 3'd4;
        cnt_max   = ks == 2'd2 ? 3'd7 : ks == 2'd1 ? 3'd5 : 3'd3;
        in_off    = key_size == 2'd2 ? 3'd0 : key_size == 2'd1 ? 3'd2 : 3'd4;
        key_shift = cipher_key >> (32 * in_off);
        prev      = win[7];
        sub_in    = cnt == 3'd0 ? {prev[23:0], prev[31:24]} : prev;
        sub       = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};
        temp      = cnt == 3'd0 ? sub ^ {rcon, 24'h0} : (ks == 2'd2 && cnt == 3'd4) ? sub : prev;
        word      = win[off] ^ temp;
    end

    // Next-state: IDLE -> GEN on accept, GEN -> DONE after the last word, DONE -> IDLE
    always_comb begin
        next_state = state;
        next_state = state == S_IDLE ? (accept ? S_GEN : S_IDLE) :
                     state == S_GEN  ? (idx == last ? S_DONE : S_GEN) : S_IDLE;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // Key load on accept, then one schedule word written and shifted in per GEN cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r <= MAX_ROUNDS; r++) rk[r] <= '0;
            for (int j = 0; j < 8; j++) win[j] <= '0;
            idx        <= '0;
            last       <= '0;
            cnt        <= '0;
            ks         <= '0;
            rcon       <= '0;
            valid_out  <= '0;
            num_rounds <= '0;
        end else if (accept) begin
            for (int r = 0; r <= MAX_ROUNDS; r++) rk[r] <= '0;
            rk[0] <= cipher_key[MAX_KEY_LEN-1 -: DATA_W];
            rk[1] <= key_size == 2'd2 ? cipher_key[DATA_W-1:0] :
                     key_size == 2'd1 ? {cipher_key[DATA_W-1:64], 64'h0} : '0;
            for (int j = 0; j < 8; j++) win[j] <= key_shift[MAX_KEY_LEN-1-32*j -: 32];
            valid_out  <= {{(MAX_ROUNDS-1){1'b0}}, key_size == 2'd2, 1'b1};
            idx        <= key_size == 2'd2 ? 6'd8  : key_size == 2'd1 ? 6'd6  : 6'd4;
            last       <= key_size == 2'd2 ? 6'd59 : key_size == 2'd1 ? 6'd51 : 6'd43;
            num_rounds <= key_size == 2'd2 ? 4'd14 : key_size == 2'd1 ? 4'd12 : 4'd10;
            cnt        <= '0;
            ks         <= key_size;
            rcon       <= 8'h01;
        end else if (state == S_GEN) begin
            rk[idx[5:2]][96-32*int'(idx[1:0]) +: 32] <= word;
            for (int j = 0; j < 7; j++) win[j] <= win[j+1];
            win[7] <= word;
            if (idx[1:0] == 2'd3) valid_out[idx[5:2]] <= 1'b1;
            idx <= idx + 6'd1;
            cnt <= cnt == cnt_max ? 3'd0 : cnt + 3'd1;
            if (cnt == 3'd0) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        end
    end

    assign ready   = state == S_IDLE;
    assign busy    = state == S_GEN;
    assign done    = state == S_DONE;
    assign rk_data = rk_addr > 4'(MAX_ROUNDS) ? '0 : rk[rk_addr];

    genvar g;
    for (g = 0; g <= MAX_ROUNDS; g++) begin : g_sk
        assign super_key[(MAX_ROUNDS-g)*DATA_W +: DATA_W] = rk[g];
    end
endmodule
